// File: rtl/long_latency_scoreboard.sv
// Long-latency scoreboard: tracks destination registers of in-flight
// multi-cycle ops (slow loads, mul/div) from issue until writeback and
// stalls ID on RAW/WAW hazards against them, so the EX/MEM and MEM/WB
// forwarding paths only ever see single-cycle producers.
module long_latency_scoreboard #(
  parameter int NREGS   = 32,
  parameter int AW      = 5,
  parameter int MAX_OUT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rs1,
  input  logic [AW-1:0]    issue_rs2,
  input  logic             issue_use_rs1,
  input  logic             issue_use_rs2,
  input  logic [AW-1:0]    issue_rd,
  input  logic             issue_reg_write,
  input  logic             issue_is_long,
  input  logic             flush,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_rd,
  output logic             stall,
  output logic [NREGS-1:0] busy_mask,
  output logic [3:0]       outstanding,
  output logic             err_spurious_wb
);

  localparam logic [3:0] MaxOutC = 4'(MAX_OUT);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [3:0]       out_q, out_d;
  logic             err_q, err_d;

  logic wb_nz;
  logic rd_nz;
  logic hz_rs1, hz_rs2, hz_rd;
  logic raw_stall, waw_stall, cap_stall;
  logic accept;
  logic set_ev, clr_ev;

  // Hazard detection; a register being written back this cycle is treated
  // as free because the WB-to-ID bypass supplies its value.
  always_comb begin
    wb_nz  = wb_valid && (wb_rd != '0);
    rd_nz  = issue_rd != '0;
    hz_rs1 = busy_q[issue_rs1] && !(wb_nz && (wb_rd == issue_rs1));
    hz_rs2 = busy_q[issue_rs2] && !(wb_nz && (wb_rd == issue_rs2));
    hz_rd  = busy_q[issue_rd]  && !(wb_nz && (wb_rd == issue_rd));

    raw_stall = (issue_use_rs1 && hz_rs1) || (issue_use_rs2 && hz_rs2);
    waw_stall = issue_reg_write && rd_nz && hz_rd;
    // A full table can still take a new long op when a writeback frees a
    // slot in the same cycle.
    cap_stall = issue_is_long && issue_reg_write && rd_nz &&
                (out_q == MaxOutC) && !wb_nz;

    stall  = issue_valid && !flush && (raw_stall || waw_stall || cap_stall);
    accept = issue_valid && !stall && !flush;
  end

  // Next-state for busy bits, in-flight count and the sticky error flag.
  always_comb begin
    set_ev = accept && issue_is_long && issue_reg_write && rd_nz;
    clr_ev = wb_nz && busy_q[wb_rd];

    busy_d = busy_q;
    if (clr_ev) busy_d[wb_rd] = 1'b0;
    // Set applied after clear so a same-register set/clear leaves it busy.
    if (set_ev) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;

    out_d = out_q;
    unique case ({set_ev, clr_ev})
      2'b10:   out_d = out_q + 4'd1;
      2'b01:   out_d = out_q - 4'd1;
      default: out_d = out_q;
    endcase

    err_d = err_q || (wb_valid && (!wb_nz || !busy_q[wb_rd]));
  end

  // State registers, cleared asynchronously so in-flight ops are forgotten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      out_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      out_q  <= out_d;
      err_q  <= err_d;
    end
  end

  assign busy_mask       = busy_q;
  assign outstanding     = out_q;
  assign err_spurious_wb = err_q;

endmodule

// File: tb/tb_long_latency_scoreboard.sv
// Directed bench for long_latency_scoreboard with hand-computed expectations.
module tb_long_latency_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic        issue_use_rs1;
  logic        issue_use_rs2;
  logic [4:0]  issue_rd;
  logic        issue_reg_write;
  logic        issue_is_long;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        stall;
  logic [31:0] busy_mask;
  logic [3:0]  outstanding;
  logic        err_spurious_wb;

  int checkCount;
  int passCount;

  long_latency_scoreboard #(.NREGS(32), .AW(5), .MAX_OUT(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .issue_valid     (issue_valid),
    .issue_rs1       (issue_rs1),
    .issue_rs2       (issue_rs2),
    .issue_use_rs1   (issue_use_rs1),
    .issue_use_rs2   (issue_use_rs2),
    .issue_rd        (issue_rd),
    .issue_reg_write (issue_reg_write),
    .issue_is_long   (issue_is_long),
    .flush           (flush),
    .wb_valid        (wb_valid),
    .wb_rd           (wb_rd),
    .stall           (stall),
    .busy_mask       (busy_mask),
    .outstanding     (outstanding),
    .err_spurious_wb (err_spurious_wb)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value and tally it
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Drive the ID and WB inputs, then let the combinational stall settle
  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2,
                               input logic [4:0] rd, input logic rw, input logic lg,
                               input logic fl, input logic wv, input logic [4:0] wr);
    issue_valid     = v;
    issue_rs1       = rs1;
    issue_use_rs1   = u1;
    issue_rs2       = rs2;
    issue_use_rs2   = u2;
    issue_rd        = rd;
    issue_reg_write = rw;
    issue_is_long   = lg;
    flush           = fl;
    wb_valid        = wv;
    wb_rd           = wr;
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance to just past the next rising edge
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Issue an unhazarded long op writing rd and clock it in
  task automatic issueLong(input logic [4:0] rd);
    applyStimulus(1, 0, 0, 0, 0, rd, 1, 1, 0, 0, 0);
    stepCycle();
  endtask

  // Write back rd with nothing issuing and clock it in
  task automatic writeBack(input logic [4:0] rd);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, rd);
    stepCycle();
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst_n      = 1'b0;
    idle();
    #2;
    checkOutput("reset_busy", busy_mask, 32'h0);
    checkOutput("reset_out", {28'h0, outstanding}, 32'd0);
    checkOutput("reset_err", {31'h0, err_spurious_wb}, 32'd0);
    checkOutput("reset_stall", {31'h0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("idle_busy", busy_mask, 32'h0);

    // RAW: long load to x5, dependent op stalls until WB of x5
    applyStimulus(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
    checkOutput("raw_issue_stall", {31'h0, stall}, 32'd0);
    stepCycle();
    checkOutput("raw_busy_set", busy_mask, 32'h0000_0020);
    checkOutput("raw_out_1", {28'h0, outstanding}, 32'd1);
    applyStimulus(1, 5, 1, 0, 0, 10, 1, 0, 0, 0, 0);
    checkOutput("raw_stall_c1", {31'h0, stall}, 32'd1);
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("raw_stall_c3", {31'h0, stall}, 32'd1);
    applyStimulus(1, 5, 1, 0, 0, 10, 1, 0, 0, 1, 5);
    checkOutput("raw_wb_exempt", {31'h0, stall}, 32'd0);
    stepCycle();
    checkOutput("raw_busy_clr", busy_mask, 32'h0);
    checkOutput("raw_out_0", {28'h0, outstanding}, 32'd0);

    // WAW on x7, and rd = x0 is never a hazard
    issueLong(7);
    checkOutput("waw_busy", busy_mask, 32'h0000_0080);
    applyStimulus(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    checkOutput("waw_stall", {31'h0, stall}, 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("waw_x0_stall", {31'h0, stall}, 32'd0);
    stepCycle();
    checkOutput("waw_x0_busy", busy_mask, 32'h0000_0080);
    checkOutput("waw_x0_out", {28'h0, outstanding}, 32'd1);
    writeBack(7);
    checkOutput("waw_cleanup", busy_mask, 32'h0);

    // Capacity: four long ops fill the table, fifth stalls unless WB frees one
    for (int r = 1; r <= 4; r++) issueLong(5'(r));
    checkOutput("cap_out_4", {28'h0, outstanding}, 32'd4);
    checkOutput("cap_busy_4", busy_mask, 32'h0000_001E);
    applyStimulus(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0);
    checkOutput("cap_stall", {31'h0, stall}, 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 9, 1, 1, 0, 1, 2);
    checkOutput("cap_wb_nostall", {31'h0, stall}, 32'd0);
    stepCycle();
    checkOutput("cap_out_keep", {28'h0, outstanding}, 32'd4);
    checkOutput("cap_busy_swap", busy_mask, 32'h0000_021A);
    checkOutput("cap_err_clean", {31'h0, err_spurious_wb}, 32'd0);
    writeBack(1);
    writeBack(3);
    writeBack(4);
    writeBack(9);
    checkOutput("cap_drained_out", {28'h0, outstanding}, 32'd0);
    checkOutput("cap_drained_busy", busy_mask, 32'h0);

    // Same-register set and clear: x12 busy, long op to x12 issued in its WB cycle
    issueLong(12);
    applyStimulus(1, 0, 0, 0, 0, 12, 1, 1, 0, 1, 12);
    checkOutput("setclr_stall", {31'h0, stall}, 32'd0);
    stepCycle();
    checkOutput("setclr_busy", busy_mask, 32'h0000_1000);
    checkOutput("setclr_out", {28'h0, outstanding}, 32'd1);
    writeBack(12);

    // Flush overrides a RAW hazard and blocks the busy set
    issueLong(3);
    applyStimulus(1, 3, 1, 0, 0, 6, 1, 1, 1, 0, 0);
    checkOutput("flush_stall", {31'h0, stall}, 32'd0);
    stepCycle();
    checkOutput("flush_busy", busy_mask, 32'h0000_0008);
    checkOutput("flush_out", {28'h0, outstanding}, 32'd1);

    // Spurious writebacks: non-busy x8, then x0
    writeBack(8);
    checkOutput("spur_err_x8", {31'h0, err_spurious_wb}, 32'd1);
    checkOutput("spur_busy_keep", busy_mask, 32'h0000_0008);
    checkOutput("spur_out_keep", {28'h0, outstanding}, 32'd1);
    writeBack(0);
    checkOutput("spur_err_x0", {31'h0, err_spurious_wb}, 32'd1);
    idle();
    stepCycle();
    checkOutput("spur_err_sticky", {31'h0, err_spurious_wb}, 32'd1);

    // Asynchronous reset mid-flight with three busy registers
    issueLong(10);
    issueLong(11);
    checkOutput("mid_out_3", {28'h0, outstanding}, 32'd3);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_busy", busy_mask, 32'h0);
    checkOutput("async_out", {28'h0, outstanding}, 32'd0);
    checkOutput("async_err", {31'h0, err_spurious_wb}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("post_reset_busy", busy_mask, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
